keypad_encoder: RTL and testbench



---
 rtl/keypad_encoder.sv | 190 +++++++++++++++++++
 tb/tb_keypad_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 matrix keypad, synchronises and debounces the
// rows, and encodes each accepted press into a 4-bit code plus class flags.
// Latency: press stable from cycle t -> key_strobe at t + 2 + DEBOUNCE + 1
// (when its column is already driven). No backpressure: key_strobe is a
// one-cycle pulse and key_code/flags hold until the next strobe.
// Ports:
//   clk, nrst             clock, synchronous active-low reset
//   row[3:0]              raw row sense lines (async, active-high)
//   col[3:0]              one-hot column drive
//   key_strobe            one-cycle pulse per accepted key
//   key_code[3:0]         code of the last accepted key
//   isdig/isop/isreg      class of the last accepted key (all 0 for 0xF)
module keypad_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_strobe,
  output logic [3:0] key_code,
  output logic       isdig,
  output logic       isop,
  output logic       isreg
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     row_meta_q, row_s_q;
  logic [3:0]     col_q, col_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic [3:0]     pat_q, pat_d;
  logic           strobe_q, strobe_d;
  logic [3:0]     code_q, code_d;
  logic           isdig_q, isdig_d;
  logic           isop_q, isop_d;
  logic           isreg_q, isreg_d;

  logic [3:0] enc_code;
  logic       pat_onehot;

  // Row/column position -> key legend.
  function automatic logic [3:0] encode(input logic [3:0] pat, input logic [3:0] colv);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] k;
    case (pat)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      default: r = 2'd3;
    endcase
    case (colv)
      4'b0001: c = 2'd0;
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hF;  4'hD: k = 4'h0;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign enc_code   = encode(pat_q, col_q);
  // A multi-row pattern cannot be resolved to a single key.
  assign pat_onehot = (pat_q != 4'b0) && ((pat_q & (pat_q - 4'd1)) == 4'b0);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    deb_d    = deb_q;
    pat_d    = pat_q;
    strobe_d = 1'b0;
    code_d   = code_q;
    isdig_d  = isdig_q;
    isop_d   = isop_q;
    isreg_d  = isreg_q;

    case (state_q)
      S_SCAN: begin
        if (row_s_q != 4'b0) begin
          // Column freezes here so the code is taken from the column that lit the row.
          pat_d   = row_s_q;
          deb_d   = '0;
          state_d = S_DEBOUNCE;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          col_d   = {col_q[2:0], col_q[3]};
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (row_s_q == pat_q) begin
          if (deb_q == DEB_LAST) begin
            deb_d = '0;
            if (pat_onehot) begin
              state_d  = S_PRESSED;
              strobe_d = 1'b1;
              code_d   = enc_code;
              isdig_d  = (enc_code <= 4'h9);
              isop_d   = (enc_code >= 4'hA) && (enc_code <= 4'hD);
              isreg_d  = (enc_code == 4'hE);
            end else begin
              state_d = S_WAIT_REL;
            end
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          // Glitch or bounce: resume scanning on the same column.
          state_d = S_SCAN;
          dwell_d = '0;
        end
      end

      default: begin  // S_PRESSED, S_WAIT_REL: wait for a clean release
        if (state_q == S_PRESSED) state_d = S_WAIT_REL;
        if (row_s_q == 4'b0) begin
          if (deb_q == DEB_LAST) begin
            state_d = S_SCAN;
            dwell_d = '0;
            deb_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_SCAN;
      row_meta_q <= 4'b0;
      row_s_q    <= 4'b0;
      col_q      <= 4'b0001;
      dwell_q    <= '0;
      deb_q      <= '0;
      pat_q      <= 4'b0;
      strobe_q   <= 1'b0;
      code_q     <= 4'h0;
      isdig_q    <= 1'b0;
      isop_q     <= 1'b0;
      isreg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
      col_q      <= col_d;
      dwell_q    <= dwell_d;
      deb_q      <= deb_d;
      pat_q      <= pat_d;
      strobe_q   <= strobe_d;
      code_q     <= code_d;
      isdig_q    <= isdig_d;
      isop_q     <= isop_d;
      isreg_q    <= isreg_d;
    end
  end

  assign col        = col_q;
  assign key_strobe = strobe_q;
  assign key_code   = code_q;
  assign isdig      = isdig_q;
  assign isop       = isop_q;
  assign isreg      = isreg_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: drives keypad_encoder through a switch-matrix model and
// checks strobes, codes, flags, scan timing and reset behaviour.
// Stimulus mixes fixed scenarios with randomized key presses.
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int LAT      = 2 + DEBOUNCE + 1;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_strobe;
  logic [3:0] key_code;
  logic       isdig, isop, isreg;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int strobe_cnt = 0, last_strobe_cyc = -1, min_gap = 1000000, consec_cnt = 0;
  int rise_cnt = 0, rise_cyc = 0;
  logic [3:0] prev_row = 4'b0;
  logic       prev_strobe = 1'b0;

  bit         key_down = 1'b0;
  int         key_r = 0, key_c = 0;
  bit         force_en = 1'b0;
  logic [3:0] force_val = 4'b0;

  // Keypad legend, indexed row*4+col.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hF, 4'h0, 4'hE, 4'hD};

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .nrst(nrst), .row(row), .col(col),
    .key_strobe(key_strobe), .key_code(key_code),
    .isdig(isdig), .isop(isop), .isreg(isreg)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed switch connects its row to its column drive.
  always_comb begin
    row = 4'b0;
    if (force_en) row = force_val;
    else if (key_down && col[key_c]) row[key_r] = 1'b1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) begin
      if (prev_strobe) consec_cnt++;
      if (last_strobe_cyc >= 0 && (cyc - last_strobe_cyc) < min_gap) min_gap = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_cnt++;
    end
    if (row != 4'b0 && prev_row == 4'b0) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_row    = row;
    prev_strobe = key_strobe;
  end

  function automatic logic [2:0] exp_flags(input logic [3:0] k);
    return {k <= 4'd9, (k >= 4'd10 && k <= 4'd13), k == 4'd14};
  endfunction

  // Press switch (r,c), hold it for 'hold' cycles after its row first lights,
  // release, and report what the DUT did.
  task automatic do_press(input int r, input int c, input int hold,
                          output int n_strb, output int lat,
                          output logic [3:0] code, output logic [2:0] flg,
                          output logic [3:0] col_hold, output logic [3:0] col_rot,
                          output bit timed_out);
    int s0, r0, t_rise;
    timed_out = 1'b0;
    for (int i = 0; i < 50 && col[c]; i++) @(negedge clk);
    @(posedge clk); #1;
    s0 = strobe_cnt;
    r0 = rise_cnt;
    key_r = r; key_c = c; key_down = 1'b1;
    for (int i = 0; i < 40 && rise_cnt == r0; i++) begin @(negedge clk); #1; end
    if (rise_cnt == r0) timed_out = 1'b1;
    t_rise = rise_cyc;
    repeat (hold) @(negedge clk);
    code = key_code;
    flg  = {isdig, isop, isreg};
    @(posedge clk); #1;
    key_down = 1'b0;
    repeat (9) @(negedge clk);
    col_hold = col;
    @(negedge clk);
    col_rot = col;
    #1;
    n_strb = strobe_cnt - s0;
    lat    = last_strobe_cyc - t_rise;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    nrst = 1'b0; force_en = 1'b1; force_val = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (col !== 4'b0001) begin n_fail++; $display("FAIL reset_col got %b want 0001", col); end
    n_tests++; if (key_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", key_strobe); end
    n_tests++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code got %h want 0", key_code); end
    n_tests++; if ({isdig, isop, isreg} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {isdig, isop, isreg}); end
    nrst = 1'b1; force_val = 4'b0000;
    repeat (3) @(negedge clk);
    n_tests++; if (col !== 4'b0001) begin n_fail++; $display("FAIL scan_dwell got %b want 0001", col); end
    exp_col = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) @(negedge clk); else repeat (SCAN_DIV) @(negedge clk);
      exp_col = {exp_col[2:0], exp_col[3]};
      n_tests++; if (col !== exp_col) begin n_fail++; $display("FAIL scan_step%0d got %b want %b", s, col, exp_col); end
    end
    force_en = 1'b0;
  endtask

  task automatic test_press5();
    int ns, lat; logic [3:0] code, ch, cr; logic [2:0] flg; bit to;
    do_press(1, 1, 40, ns, lat, code, flg, ch, cr, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL press5_row_timeout got timeout want row seen"); end
    n_tests++; if (ns !== 1) begin n_fail++; $display("FAIL press5_strobes got %0d want 1", ns); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL press5_latency got %0d want %0d", lat, LAT); end
    n_tests++; if (code !== 4'h5) begin n_fail++; $display("FAIL press5_code got %h want 5", code); end
    n_tests++; if (flg !== 3'b100) begin n_fail++; $display("FAIL press5_flags got %b want 100", flg); end
    n_tests++; if (ch !== 4'b0010) begin n_fail++; $display("FAIL press5_col_hold got %b want 0010", ch); end
    n_tests++; if (cr !== 4'b0100) begin n_fail++; $display("FAIL press5_col_resume got %b want 0100", cr); end
  endtask

  task automatic test_bounce();
    int s0; logic [3:0] ca, exp_c;
    @(posedge clk); #1;
    s0 = strobe_cnt;
    force_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      force_val = 4'b0010; repeat (2) begin @(posedge clk); #1; end
      force_val = 4'b0000; repeat (2) begin @(posedge clk); #1; end
    end
    repeat (6) @(negedge clk);
    ca = col;
    repeat (3 * SCAN_DIV) @(negedge clk);
    #1;
    exp_c = {ca[0], ca[3:1]};
    n_tests++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL bounce_strobes got %0d want 0", strobe_cnt - s0); end
    n_tests++; if (col !== exp_c) begin n_fail++; $display("FAIL bounce_col_rotate got %b want %b", col, exp_c); end
    force_en = 1'b0;
  endtask

  task automatic test_classes();
    int rs [3] = '{0, 3, 3};
    int cs [3] = '{3, 2, 0};
    logic [3:0] want_code [3] = '{4'hA, 4'hE, 4'hF};
    logic [2:0] want_flg  [3] = '{3'b010, 3'b001, 3'b000};
    int ns, lat; logic [3:0] code, ch, cr; logic [2:0] flg; bit to;
    for (int k = 0; k < 3; k++) begin
      do_press(rs[k], cs[k], 20, ns, lat, code, flg, ch, cr, to);
      n_tests++; if (to || ns !== 1) begin n_fail++; $display("FAIL class%0d_strobes got %0d want 1", k, ns); end
      n_tests++; if (code !== want_code[k]) begin n_fail++; $display("FAIL class%0d_code got %h want %h", k, code, want_code[k]); end
      n_tests++; if (flg !== want_flg[k]) begin n_fail++; $display("FAIL class%0d_flags got %b want %b", k, flg, want_flg[k]); end
    end
  endtask

  task automatic test_multikey();
    int s0, bad; logic [3:0] ch, cr;
    bad = 0;
    for (int i = 0; i < 40 && col !== 4'b1000; i++) @(negedge clk);
    for (int i = 0; i < 10 && col !== 4'b0001; i++) @(negedge clk);
    @(posedge clk); #1;
    s0 = strobe_cnt;
    force_en = 1'b1; force_val = 4'b0011;
    repeat (20) begin @(negedge clk); if (col !== 4'b0001) bad++; end
    @(posedge clk); #1;
    force_val = 4'b0000;
    repeat (9) @(negedge clk);
    ch = col;
    @(negedge clk);
    cr = col;
    #1;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL multi_col_frozen got %0d moves want 0", bad); end
    n_tests++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL multi_strobes got %0d want 0", strobe_cnt - s0); end
    n_tests++; if (ch !== 4'b0001) begin n_fail++; $display("FAIL multi_col_release got %b want 0001", ch); end
    n_tests++; if (cr !== 4'b0010) begin n_fail++; $display("FAIL multi_col_resume got %b want 0010", cr); end
    n_tests++; if (key_code !== 4'hF || {isdig, isop, isreg} !== 3'b000) begin
      n_fail++; $display("FAIL multi_code_kept got %h/%b want f/000", key_code, {isdig, isop, isreg});
    end
    force_en = 1'b0;
  endtask

  task automatic test_random();
    int r, c, hold, ns, lat; logic [3:0] code, ch, cr, wc; logic [2:0] flg; bit to;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      hold = $urandom_range(8, 30);
      wc = keymap[r * 4 + c];
      do_press(r, c, hold, ns, lat, code, flg, ch, cr, to);
      n_tests++; if (to || ns !== 1 || lat !== LAT) begin
        n_fail++; $display("FAIL rand%0d_strobe got %0d strobes lat %0d want 1 lat %0d", k, ns, lat, LAT);
      end
      n_tests++; if (code !== wc || flg !== exp_flags(wc)) begin
        n_fail++; $display("FAIL rand%0d_code r%0d c%0d got %h/%b want %h/%b", k, r, c, code, flg, wc, exp_flags(wc));
      end
    end
  endtask

  task automatic test_reset_midpress();
    int s0, r0; bit got;
    // Reset while debouncing.
    for (int i = 0; i < 50 && col[1]; i++) @(negedge clk);
    @(posedge clk); #1;
    s0 = strobe_cnt; r0 = rise_cnt;
    key_r = 1; key_c = 1; key_down = 1'b1;
    for (int i = 0; i < 40 && rise_cnt == r0; i++) begin @(negedge clk); #1; end
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (col !== 4'b0001 || key_code !== 4'h0 || key_strobe !== 1'b0) begin
      n_fail++; $display("FAIL rst_deb_state got col %b code %h strobe %b want 0001 0 0", col, key_code, key_strobe);
    end
    n_tests++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL rst_deb_nostrobe got %0d want 0", strobe_cnt - s0); end
    repeat (30) @(negedge clk); #1;
    n_tests++; if (strobe_cnt - s0 !== 1 || key_code !== 4'h5) begin
      n_fail++; $display("FAIL rst_deb_repress got %0d strobes code %h want 1 code 5", strobe_cnt - s0, key_code);
    end
    @(posedge clk); #1; key_down = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the strobe (PRESSED) cycle.
    for (int i = 0; i < 50 && col[1]; i++) @(negedge clk);
    @(posedge clk); #1;
    key_r = 1; key_c = 1; key_down = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); got = (key_strobe === 1'b1); end
    n_tests++; if (!got) begin n_fail++; $display("FAIL rst_prs_first_strobe got timeout want strobe"); end
    nrst = 1'b0;
    #1;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (col !== 4'b0001 || key_code !== 4'h0 || key_strobe !== 1'b0) begin
      n_fail++; $display("FAIL rst_prs_state got col %b code %h strobe %b want 0001 0 0", col, key_code, key_strobe);
    end
    repeat (30) @(negedge clk); #1;
    n_tests++; if (strobe_cnt - s0 !== 1 || key_code !== 4'h5 || {isdig, isop, isreg} !== 3'b100) begin
      n_fail++; $display("FAIL rst_prs_repress got %0d strobes code %h want 1 code 5", strobe_cnt - s0, key_code);
    end
    @(posedge clk); #1; key_down = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_spacing();
    n_tests++; if (consec_cnt !== 0) begin n_fail++; $display("FAIL strobe_consecutive got %0d want 0", consec_cnt); end
    n_tests++; if (min_gap < 2 * DEBOUNCE) begin n_fail++; $display("FAIL strobe_gap got %0d want >= %0d", min_gap, 2 * DEBOUNCE); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press5();
    test_bounce();
    test_classes();
    test_multikey();
    test_random();
    test_reset_midpress();
    test_spacing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
